// File: rtl/tdr_pkg.sv
// tdr_pkg: shared types and default constants for the time_domain_register
// write sequencer.
//   tdr_state_e : sequencer phases
//   tdr_op_e    : host command opcode
//   DEF_*       : default parameter values
//   cnt_width() : width of the shared phase down-counter
package tdr_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_GAP_CYC    = 2;
  localparam int DEF_WE1_CYC    = 2;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_RD_TIMEOUT = 300;

  typedef enum logic [2:0] {
    IDLE,
    WE0,
    GAP,
    WE1,
    SETTLE,
    READ,
    DONE
  } tdr_state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } tdr_op_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The counter must hold the longest phase reload value and any interval code.
  function automatic int cnt_width(input int data_w, input int gap_cyc,
                                   input int we1_cyc, input int settle_cyc,
                                   input int rd_timeout);
    int longest;
    longest = max_int(max_int(gap_cyc, we1_cyc), max_int(settle_cyc, rd_timeout));
    return max_int(data_w, $clog2(longest + 1));
  endfunction

endpackage

// File: rtl/tdr_sync2.sv
// tdr_sync2: generic two-flop synchronizer with asynchronous active-low reset.
//   clk_i  : destination clock
//   rstb_i : asynchronous reset, active low; both stages clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clk_i edges of latency)
module tdr_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rstb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      meta <= '0;
      q_o  <= '0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/tdr_write_sequencer.sv
// tdr_write_sequencer: turns a host interval code into the WE0 / gap / WE1
// write sequence for time_domain_register, and on a read opens an RE window
// and measures the width of the returned out pulse in clock cycles.
//
// Ports:
//   clk_i, rstb_i         : clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   : command handshake, ready only while idle
//   cmd_op_i              : 0 = write, 1 = read
//   cmd_data_i            : interval code (WE0 width in cycles), writes only
//   we0_o, we1_o, re_o    : register enables, registered, at most one high
//   tdr_out_i             : register out pulse, asynchronous to clk_i
//   rsp_valid_o           : one-cycle completion pulse
//   rsp_data_o            : measured width (reads), 0 for plain writes
//   rsp_timeout_o         : read window expired before the pulse ended
//
// Build option:
//   TDR_SEQ_AUTO_READ_EN  : writes continue into SETTLE/READ after WE1 and
//                           report the read-back width (write-verify).
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready_o high
// WE0    | we0_o high for code cycles
// GAP    | all enables low for GAP_CYC cycles
// WE1    | we1_o high for WE1_CYC cycles
// SETTLE | all enables low for SETTLE_CYC cycles before reading
// READ   | re_o high, counting synchronized out-high cycles
// DONE   | rsp_valid_o high for one cycle
module tdr_write_sequencer
  import tdr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int WE1_CYC    = DEF_WE1_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rstb_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              we0_o,
  output logic              we1_o,
  output logic              re_o,
  input  logic              tdr_out_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_timeout_o
);

  localparam int CNT_W = cnt_width(DATA_W, GAP_CYC, WE1_CYC, SETTLE_CYC, RD_TIMEOUT);
  localparam logic [DATA_W-1:0] MEAS_MAX = '1;

  tdr_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] meas;
  logic [DATA_W-1:0] meas_nxt;
  logic              seen_high;
  logic              tdr_out_s;
  logic              cnt_done;
  tdr_op_e           op_in;

  tdr_sync2 #(.WIDTH(1)) u_sync (
    .clk_i  (clk_i),
    .rstb_i (rstb_i),
    .d_i    (tdr_out_i),
    .q_o    (tdr_out_s)
  );

  assign op_in    = tdr_op_e'(cmd_op_i);
  assign cnt_done = (cnt == '0);
  // Saturating width counter; on timeout the current sample is still counted.
  assign meas_nxt = (tdr_out_s && (meas != MEAS_MAX)) ? meas + DATA_W'(1) : meas;

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state         <= IDLE;
      cnt           <= '0;
      meas          <= '0;
      seen_high     <= 1'b0;
      cmd_ready_o   <= 1'b1;
      we0_o         <= 1'b0;
      we1_o         <= 1'b0;
      re_o          <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            if (op_in == OP_READ) begin
              state <= SETTLE;
              cnt   <= CNT_W'(SETTLE_CYC - 1);
            end else if (cmd_data_i == '0) begin
              // Zero-length code skips WE0 entirely.
              state <= GAP;
              cnt   <= CNT_W'(GAP_CYC - 1);
            end else begin
              state <= WE0;
              we0_o <= 1'b1;
              cnt   <= CNT_W'(cmd_data_i) - CNT_W'(1);
            end
          end
        end

        WE0: begin
          if (cnt_done) begin
            state <= GAP;
            we0_o <= 1'b0;
            cnt   <= CNT_W'(GAP_CYC - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt_done) begin
            state <= WE1;
            we1_o <= 1'b1;
            cnt   <= CNT_W'(WE1_CYC - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        WE1: begin
          if (cnt_done) begin
            we1_o <= 1'b0;
`ifdef TDR_SEQ_AUTO_READ_EN
            // Only writes ever reach WE1, so no opcode needs to be kept.
            state <= SETTLE;
            cnt   <= CNT_W'(SETTLE_CYC - 1);
`else
            state         <= DONE;
            rsp_valid_o   <= 1'b1;
            rsp_data_o    <= '0;
            rsp_timeout_o <= 1'b0;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        SETTLE: begin
          if (cnt_done) begin
            state     <= READ;
            re_o      <= 1'b1;
            cnt       <= CNT_W'(RD_TIMEOUT - 1);
            meas      <= '0;
            seen_high <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        READ: begin
          meas <= meas_nxt;
          if (tdr_out_s) begin
            seen_high <= 1'b1;
          end
          if (!tdr_out_s && seen_high) begin
            state         <= DONE;
            re_o          <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_data_o    <= meas;
            rsp_timeout_o <= 1'b0;
          end else if (cnt_done) begin
            state         <= DONE;
            re_o          <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_data_o    <= meas_nxt;
            rsp_timeout_o <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          state         <= IDLE;
          cmd_ready_o   <= 1'b1;
          rsp_valid_o   <= 1'b0;
          rsp_data_o    <= '0;
          rsp_timeout_o <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          cmd_ready_o   <= 1'b1;
          we0_o         <= 1'b0;
          we1_o         <= 1'b0;
          re_o          <= 1'b0;
          rsp_valid_o   <= 1'b0;
          rsp_data_o    <= '0;
          rsp_timeout_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdr_write_sequencer.sv
`timescale 1ns/1ps
module tb_tdr_write_sequencer;
  import tdr_pkg::*;

  localparam int DW      = 8;
  localparam int G       = 2;
  localparam int W1      = 2;
  localparam int S       = 4;
  localparam int RD      = 300;
  localparam int RD_LONG = 1000;
`ifdef TDR_SEQ_AUTO_READ_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_valid_l = 1'b0;
  logic          cmd_op = 1'b0;
  logic [DW-1:0] cmd_data = '0;
  logic          tdr_out = 1'b0;

  logic          rdy, we0, we1, re, rv, tmo;
  logic [DW-1:0] rdata;
  logic          rdy_l, we0_l, we1_l, re_l, rv_l, tmo_l;
  logic [DW-1:0] rdata_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tdr_write_sequencer #(
    .DATA_W(DW), .GAP_CYC(G), .WE1_CYC(W1), .SETTLE_CYC(S), .RD_TIMEOUT(RD)
  ) dut (
    .clk_i(clk), .rstb_i(rstb), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy),
    .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .we0_o(we0), .we1_o(we1),
    .re_o(re), .tdr_out_i(tdr_out), .rsp_valid_o(rv), .rsp_data_o(rdata),
    .rsp_timeout_o(tmo)
  );

  tdr_write_sequencer #(
    .DATA_W(DW), .GAP_CYC(G), .WE1_CYC(W1), .SETTLE_CYC(S), .RD_TIMEOUT(RD_LONG)
  ) dut_l (
    .clk_i(clk), .rstb_i(rstb), .cmd_valid_i(cmd_valid_l), .cmd_ready_o(rdy_l),
    .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .we0_o(we0_l), .we1_o(we1_l),
    .re_o(re_l), .tdr_out_i(tdr_out), .rsp_valid_o(rv_l), .rsp_data_o(rdata_l),
    .rsp_timeout_o(tmo_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({we0, we1, re, rv, tmo, rdy} !== 6'b000001 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state: {we0,we1,re,rv,tmo,rdy}=%b data=%0d required 000001 data=0",
               {we0, we1, re, rv, tmo, rdy}, rdata);
    end
    n_tests++;
    if ({we0_l, we1_l, re_l, rv_l, tmo_l, rdy_l} !== 6'b000001 || rdata_l !== '0) begin
      n_fail++;
      $display("FAIL reset_state_long: {we0,we1,re,rv,tmo,rdy}=%b required 000001",
               {we0_l, we1_l, re_l, rv_l, tmo_l, rdy_l});
    end
    rstb = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({we0, we1, re, rv, rdy} !== 5'b00001) begin
      n_fail++;
      $display("FAIL idle_after_reset: {we0,we1,re,rv,rdy}=%b required 00001",
               {we0, we1, re, rv, rdy});
    end
  endtask

  // Starts on the first sample after the accepting edge (t=1) and ends on the
  // first idle sample after the response.
  task automatic check_write_wave(input int c);
    int rsp_t = c + G + W1 + 1 + (AUTO ? S + RD : 0);
    int re_lo = c + G + W1 + S;
    int bad_t = -1;
    logic [4:0] exp_v, obs_v, bad_obs, bad_exp;
    bad_obs = '0;
    bad_exp = '0;
    for (int t = 1; t <= rsp_t + 1; t++) begin
      exp_v = {(t <= c), (t > c + G && t <= c + G + W1),
               (AUTO && t > re_lo && t <= re_lo + RD), (t == rsp_t), (t == rsp_t + 1)};
      obs_v = {we0, we1, re, rv, rdy};
      if (obs_v !== exp_v && bad_t < 0) begin
        bad_t   = t;
        bad_obs = obs_v;
        bad_exp = exp_v;
      end
      if (t == rsp_t) begin
        n_tests++;
        if (rdata !== '0 || tmo !== AUTO) begin
          n_fail++;
          $display("FAIL write_rsp code=%0d: data=%0d tmo=%b required data=0 tmo=%b",
                   c, rdata, tmo, AUTO);
        end
      end
      if (t <= rsp_t) tick();
    end
    n_tests++;
    if (bad_t >= 0) begin
      n_fail++;
      $display("FAIL write_wave code=%0d t=%0d: {we0,we1,re,rv,rdy}=%b required %b",
               c, bad_t, bad_obs, bad_exp);
    end
  endtask

  task automatic test_write(input int c);
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ready: cmd_ready=%b required 1", rdy);
    end
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_data  = DW'(c);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = DW'($urandom);
    check_write_wave(c);
  endtask

  task automatic test_back_to_back(input int c1, input int c2);
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_data  = DW'(c1);
    tick();
    cmd_data = DW'(c2);
    check_write_wave(c1);
    tick();
    cmd_valid = 1'b0;
    check_write_wave(c2);
  endtask

  // Issues a command, waits for re to rise, then shapes tdr_out as low for d
  // cycles and high for w cycles (w < 0: stays high) until a response shows.
  task automatic read_txn(input bit lng, input bit op, input int code, input int d,
                          input int w, output int rise_t, output int rsp_t,
                          output int data, output bit tmo_o, output bit re_at);
    int lim = (lng ? RD_LONG : RD) + 20;
    rise_t = -1;
    rsp_t  = -1;
    data   = 0;
    tmo_o  = 1'b0;
    re_at  = 1'b0;
    n_tests++;
    if ((lng ? rdy_l : rdy) !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_before: cmd_ready=%b required 1", lng ? rdy_l : rdy);
    end
    cmd_op   = op;
    cmd_data = DW'(code);
    if (lng) cmd_valid_l = 1'b1;
    else     cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
    cmd_valid_l = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if ((lng ? re_l : re) === 1'b1) begin
        rise_t = k;
        break;
      end
      tick();
    end
    if (rise_t < 0) return;
    for (int j = 0; j <= lim; j++) begin
      if ((lng ? rv_l : rv) === 1'b1) begin
        rsp_t = j;
        data  = int'(lng ? rdata_l : rdata);
        tmo_o = lng ? tmo_l : tmo;
        re_at = lng ? re_l : re;
        break;
      end
      tdr_out = (j >= d) && (w < 0 || j < d + w);
      tick();
    end
    tdr_out = 1'b0;
    tick();
  endtask

  task automatic test_read_pulse(input int d, input int w);
    int rise_t, rsp_t, data;
    bit t_o, re_at;
    read_txn(1'b0, 1'b1, $urandom_range(0, 255), d, w, rise_t, rsp_t, data, t_o, re_at);
    n_tests++;
    if (rsp_t < 0) begin
      n_fail++;
      $display("FAIL read_pulse_rsp d=%0d w=%0d: no response (re rise t=%0d) required one", d, w, rise_t);
    end else if (data < w - 1 || data > w + 1 || t_o !== 1'b0 || re_at !== 1'b0
                 || rsp_t < d + w + 2 || rsp_t > d + w + 4) begin
      n_fail++;
      $display("FAIL read_pulse d=%0d w=%0d: data=%0d tmo=%b re=%b rsp_t=%0d required data=%0d+-1 tmo=0 re=0 rsp_t=%0d+-1",
               d, w, data, t_o, re_at, rsp_t, w, d + w + 3);
    end
  endtask

  task automatic test_read_timeout();
    int rise_t, rsp_t, data;
    bit t_o, re_at;
    read_txn(1'b0, 1'b1, 0, 0, 0, rise_t, rsp_t, data, t_o, re_at);
    n_tests++;
    if (rise_t != S + 1) begin
      n_fail++;
      $display("FAIL read_settle: re rose at t=%0d required %0d", rise_t, S + 1);
    end
    n_tests++;
    if (rsp_t != RD || data != 0 || t_o !== 1'b1 || re_at !== 1'b0) begin
      n_fail++;
      $display("FAIL read_timeout: rsp_t=%0d data=%0d tmo=%b re=%b required rsp_t=%0d data=0 tmo=1 re=0",
               rsp_t, data, t_o, re_at, RD);
    end
  endtask

  // Pulse rises late in the window and never falls: count-so-far on timeout.
  task automatic test_timeout_count(input int d);
    int rise_t, rsp_t, data, exp_cnt;
    bit t_o, re_at;
    exp_cnt = RD - d - 2;
    read_txn(1'b0, 1'b1, 0, d, -1, rise_t, rsp_t, data, t_o, re_at);
    n_tests++;
    if (rsp_t != RD || t_o !== 1'b1 || data < exp_cnt - 1 || data > exp_cnt + 1) begin
      n_fail++;
      $display("FAIL timeout_count d=%0d: rsp_t=%0d data=%0d tmo=%b required rsp_t=%0d data=%0d+-1 tmo=1",
               d, rsp_t, data, t_o, RD, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    int rise_t, rsp_t, data;
    bit t_o, re_at;
    read_txn(1'b1, 1'b1, 0, 5, 400, rise_t, rsp_t, data, t_o, re_at);
    n_tests++;
    if (rsp_t < 0 || data != (1 << DW) - 1 || t_o !== 1'b0) begin
      n_fail++;
      $display("FAIL saturation: rsp_t=%0d data=%0d tmo=%b required data=%0d tmo=0",
               rsp_t, data, t_o, (1 << DW) - 1);
    end
  endtask

  task automatic test_reset_midwrite();
    int bad = 0;
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_data  = DW'(50);
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    n_tests++;
    if (we0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midwrite_we0: we0=%b required 1", we0);
    end
    #2 rstb = 1'b0;
    #1;
    n_tests++;
    if ({we0, we1, re, rv, rdy} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async_reset: {we0,we1,re,rv,rdy}=%b required 00001", {we0, we1, re, rv, rdy});
    end
    repeat (2) tick();
    rstb = 1'b1;
    for (int t = 0; t < 70; t++) begin
      if ({we0, we1, re, rv, rdy} !== 5'b00001) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL after_reset_quiet: %0d cycles with activity required 0", bad);
    end
  endtask

`ifdef TDR_SEQ_AUTO_READ_EN
  task automatic test_auto_read(input int c, input int w);
    int rise_t, rsp_t, data;
    bit t_o, re_at;
    read_txn(1'b0, 1'b0, c, 2, w, rise_t, rsp_t, data, t_o, re_at);
    n_tests++;
    if (rise_t != c + G + W1 + S + 1 || data == 0 || data < w - 1 || data > w + 1 || t_o !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_read code=%0d: rise_t=%0d data=%0d tmo=%b required rise_t=%0d data=%0d+-1 tmo=0",
               c, rise_t, data, t_o, c + G + W1 + S + 1, w);
    end
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write(5);
    test_write(0);
    test_write(1);
    for (int i = 0; i < 6; i++) test_write($urandom_range(0, 40));
    test_back_to_back($urandom_range(1, 20), $urandom_range(1, 20));
    test_back_to_back(7, 0);
    test_read_pulse(3, 37);
    test_read_pulse(0, 1);
    for (int i = 0; i < 4; i++) test_read_pulse($urandom_range(0, 10), $urandom_range(2, 200));
    test_read_timeout();
    test_timeout_count(200);
    test_saturation();
    test_reset_midwrite();
`ifdef TDR_SEQ_AUTO_READ_EN
    test_auto_read(20, 30);
    test_auto_read(20, 30);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
